// File: rtl/lock_chamber_ctrl.sv
// Canal-lock chamber sequencer: IDLE -> ENTER -> FILL -> EXIT -> DRAIN -> IDLE with dwell timer and trip counter.
// Optional macro LOCK_PENDING_EN adds a 1-deep pending-arrival flag; undefined by default.
module lock_chamber_ctrl #(
    parameter int GATE_CYCLES = 8,
    parameter int FILL_CYCLES = 16,
    parameter int TRIP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arrive,
    input  logic              depart,
    output logic              outer_gate,
    output logic              inner_gate,
    output logic              fill_valve,
    output logic              drain_valve,
    output logic              occupied,
    output logic [TRIP_W-1:0] trips
);

    localparam int MAX_CYCLES = (GATE_CYCLES > FILL_CYCLES) ? GATE_CYCLES : FILL_CYCLES;
    localparam int TMR_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTER = 3'd1,
        S_FILL  = 3'd2,
        S_EXIT  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [TMR_W-1:0]  r_timer;
    logic              w_pending;
    logic              w_trip_done;
    logic              w_outer;
    logic              w_inner;
    logic              w_fill;
    logic              w_drain;
    logic              w_occupied;

`ifdef LOCK_PENDING_EN
    logic r_pending;

    // Flag is consumed on the IDLE -> ENTER hand-off; further arrivals while set are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
        end else if (r_state == S_IDLE && w_state_nxt == S_ENTER) begin
            r_pending <= 1'b0;
        end else if (r_state != S_IDLE && arrive) begin
            r_pending <= 1'b1;
        end
    end

    assign w_pending = r_pending;
`else
    assign w_pending = 1'b0;
`endif

    assign w_trip_done = (r_state == S_DRAIN) && (w_state_nxt == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            trips       <= '0;
            outer_gate  <= 1'b0;
            inner_gate  <= 1'b0;
            fill_valve  <= 1'b0;
            drain_valve <= 1'b0;
            occupied    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            outer_gate  <= w_outer;
            inner_gate  <= w_inner;
            fill_valve  <= w_fill;
            drain_valve <= w_drain;
            occupied    <= w_occupied;
            // Timer restarts at 0 on every state entry and idles at 0 in untimed states.
            if (w_state_nxt != r_state || r_state == S_IDLE || r_state == S_EXIT) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
            if (w_trip_done) begin
                trips <= trips + TRIP_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (arrive || w_pending) w_state_nxt = S_ENTER;
            end
            S_ENTER: begin
                if (r_timer == TMR_W'(GATE_CYCLES - 1)) w_state_nxt = S_FILL;
            end
            S_FILL: begin
                if (r_timer == TMR_W'(FILL_CYCLES - 1)) w_state_nxt = S_EXIT;
            end
            S_EXIT: begin
                if (depart) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_timer == TMR_W'(FILL_CYCLES - 1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state.
    always_comb begin
        w_outer    = 1'b0;
        w_inner    = 1'b0;
        w_fill     = 1'b0;
        w_drain    = 1'b0;
        w_occupied = 1'b0;
        case (w_state_nxt)
            S_ENTER: begin
                w_outer    = 1'b1;
                w_occupied = 1'b1;
            end
            S_FILL: begin
                w_fill     = 1'b1;
                w_occupied = 1'b1;
            end
            S_EXIT: begin
                w_inner    = 1'b1;
                w_occupied = 1'b1;
            end
            S_DRAIN: begin
                w_drain    = 1'b1;
            end
            default: begin
                w_occupied = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Self-checking bench for lock_chamber_ctrl: timeline-based reference model plus directed literal checks.
// Honours LOCK_PENDING_EN the same way the design does.
module tb_lock_chamber_ctrl;

    localparam int G  = 3;
    localparam int F  = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arrive = 1'b0;
    logic          depart = 1'b0;
    logic          outer_gate;
    logic          inner_gate;
    logic          fill_valve;
    logic          drain_valve;
    logic          occupied;
    logic [TW-1:0] trips;

    int checks   = 0;
    int failures = 0;

    lock_chamber_ctrl #(
        .GATE_CYCLES(G),
        .FILL_CYCLES(F),
        .TRIP_W     (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arrive     (arrive),
        .depart     (depart),
        .outer_gate (outer_gate),
        .inner_gate (inner_gate),
        .fill_valve (fill_valve),
        .drain_valve(drain_valve),
        .occupied   (occupied),
        .trips      (trips)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a trip is described by its start edge s and depart edge u.
    // After edge n the chamber is in "cycle n"; the phase is pure arithmetic on (n, s, u).
    bit     m_active = 1'b0;
    bit     m_pend   = 1'b0;
    longint m_s      = 0;
    longint m_u      = -1;
    longint n        = 0;
    int     m_trips  = 0;

    // 0 idle, 1 gate open for entry, 2 filling, 3 waiting at inner gate, 4 draining
    function automatic int phase(input longint c);
        longint k;
        if (!m_active) return 0;
        k = c - m_s;
        if (k < G) return 1;
        if (k < G + F) return 2;
        if (m_u < 0 || c < m_u) return 3;
        if (c < m_u + F) return 4;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int ph;
        n = n + 1;
        if (!rst) begin
            m_active = 1'b0;
            m_pend   = 1'b0;
            m_trips  = 0;
        end else begin
            ph = phase(n - 1);
            if (!m_active) begin
                if (arrive || m_pend) begin
                    m_active = 1'b1;
                    m_s      = n;
                    m_u      = -1;
                    m_pend   = 1'b0;
                end
            end else begin
`ifdef LOCK_PENDING_EN
                if (arrive) m_pend = 1'b1;
`endif
                if (ph == 3 && depart) begin
                    m_u = n;
                end else if (ph == 4 && n == m_u + F) begin
                    m_active = 1'b0;
                    m_trips  = (m_trips + 1) % (1 << TW);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        int ph;
        if (rst) begin
            ph = phase(n);
            chk("model_outer_gate",  outer_gate,  (ph == 1));
            chk("model_fill_valve",  fill_valve,  (ph == 2));
            chk("model_inner_gate",  inner_gate,  (ph == 3));
            chk("model_drain_valve", drain_valve, (ph == 4));
            chk("model_occupied",    occupied,    (ph >= 1 && ph <= 3));
            chk("model_trips",       trips,       m_trips);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inner();
        int k = 0;
        while (!inner_gate && k < 60) begin
            step();
            k++;
        end
        chk("wait_inner_gate", inner_gate, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((outer_gate | inner_gate | fill_valve | drain_valve | occupied) && k < 60) begin
            step();
            k++;
        end
        chk("wait_idle", {outer_gate, inner_gate, fill_valve, drain_valve, occupied}, 0);
    endtask

    task automatic one_trip();
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        wait_inner();
        depart = 1'b1;
        step();
        depart = 1'b0;
        wait_idle();
    endtask

    task automatic sync_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        // Reset held with an arrive pulse inside it
        step();
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        step();
        chk("rst_outer",  outer_gate,  0);
        chk("rst_inner",  inner_gate,  0);
        chk("rst_fill",   fill_valve,  0);
        chk("rst_drain",  drain_valve, 0);
        chk("rst_occ",    occupied,    0);
        chk("rst_trips",  trips,       0);
        rst = 1'b1;
        step();
        step();
        chk("post_rst_idle", {outer_gate, inner_gate, fill_valve, drain_valve, occupied}, 0);

        // Full trip against the literal timeline (i = cycles after the arrive edge)
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("trip_outer", outer_gate, (i <= 3));
            chk("trip_fill",  fill_valve, (i >= 4 && i <= 7));
            chk("trip_inner", inner_gate, (i == 8));
            chk("trip_occ",   occupied,   1);
            if (i < 8) step();
        end
        step();
        step();
        chk("exit_holds", inner_gate, 1);
        depart = 1'b1;
        step();
        depart = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valve", drain_valve, 1);
            chk("drain_occ",   occupied,    0);
            step();
        end
        chk("trip_end_idle", {outer_gate, inner_gate, fill_valve, drain_valve, occupied}, 0);
        chk("trip_end_trips", trips, 1);

        // Spurious depart in IDLE and FILL, arrive during FILL
        depart = 1'b1;
        step();
        depart = 1'b0;
        step();
        chk("idle_depart_outer", outer_gate, 0);
        chk("idle_depart_trips", trips, 1);
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        step();
        step();
        step();
        chk("fill_reached", fill_valve, 1);
        depart = 1'b1;
        step();
        depart = 1'b0;
        chk("fill_depart_ignored", fill_valve, 1);
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        wait_inner();
        depart = 1'b1;
        step();
        depart = 1'b0;
        wait_idle();
        chk("spurious_trips", trips, 2);
        step();
`ifdef LOCK_PENDING_EN
        chk("pending_reenter", outer_gate, 1);
`else
        chk("no_pending_stays_idle", outer_gate, 0);
`endif

        // Asynchronous reset during FILL
        sync_reset();
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        step();
        step();
        step();
        chk("pre_areset_fill", fill_valve, 1);
        #2 rst = 1'b0;
        #1;
        chk("areset_fill", fill_valve, 0);
        chk("areset_occ",  occupied,   0);
        chk("areset_trips", trips,     0);
        step();
        rst = 1'b1;
        step();
        chk("areset_idle", {outer_gate, inner_gate, fill_valve, drain_valve, occupied}, 0);
        one_trip();
        chk("areset_fresh_trip", trips, 1);

        // Simultaneous arrive + depart while waiting at the inner gate
        arrive = 1'b1;
        step();
        arrive = 1'b0;
        wait_inner();
        arrive = 1'b1;
        depart = 1'b1;
        step();
        arrive = 1'b0;
        depart = 1'b0;
        chk("simul_drain", drain_valve, 1);
        wait_idle();
        chk("simul_trips", trips, 2);
        step();
`ifdef LOCK_PENDING_EN
        chk("simul_pending_enter", outer_gate, 1);
`else
        chk("simul_no_pending", outer_gate, 0);
`endif

        // Randomized pulses, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            arrive = ($urandom_range(0, 9) == 0);
            depart = ($urandom_range(0, 4) == 0);
            step();
        end
        arrive = 1'b0;
        depart = 1'b0;

        // Trip counter wrap
        sync_reset();
        for (int t = 0; t < 256; t++) begin
            one_trip();
            if (t == 254) chk("trips_allones", trips, 255);
        end
        chk("trips_wrap", trips, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
